// File: rtl/mult_arb_pkg.sv
// rtl/mult_arb_pkg.sv - shared state encoding and width helpers for the mult arbiter
package mult_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

    localparam int DEF_NREQ    = 4;
    localparam int DEF_WIDTH   = 8;
    localparam int DEF_TIMEOUT = 64;
    localparam int DEF_TMO_W   = $clog2(DEF_TIMEOUT);

    // Counter width able to hold TIMEOUT-1; never zero bits wide.
    function automatic int tmo_width(input int timeout);
        return (timeout > 1) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/mult_arbiter_rr_pick.sv
// rtl/mult_arbiter_rr_pick.sv - combinational round-robin pick: first request after last
module rr_pick
    import mult_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int IW   = $clog2(DEF_NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [IW-1:0]   gnt_idx,
    output logic            any
);

    int j;

    // Walk from farthest to nearest so the nearest set bit after last wins.
    always_comb begin
        gnt_idx = '0;
        any     = |req;
        j       = 0;
        for (int k = NREQ; k >= 1; k--) begin
            j = int'(last) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (req[IW'(j)]) begin
                gnt_idx = IW'(j);
            end
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// rtl/mult_arbiter.sv - shares one multicycle multiplier among NREQ requesters
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int NREQ    = DEF_NREQ,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic [NREQ-1:0]         req_ready,
    output logic [NREQ-1:0]         resp_valid,
    output logic [2*WIDTH-1:0]      resp_y,
    output logic                    resp_err,
    output logic                    mult_start,
    output logic [WIDTH-1:0]        mult_a,
    output logic [WIDTH-1:0]        mult_b,
    input  logic                    mult_busy,
    input  logic [2*WIDTH-1:0]      mult_y
);

    localparam int              IW       = $clog2(NREQ);
    localparam int              TW       = tmo_width(TIMEOUT);
    localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [IW-1:0]   LAST_RST = IW'(NREQ - 1);

    arb_state_t         r_state, w_state_nxt;
    logic [TW-1:0]      r_tmo, w_tmo_nxt;
    logic [IW-1:0]      r_grant, w_grant_nxt;
    logic [IW-1:0]      r_last, w_last_nxt;
    logic [NREQ-1:0]    r_ready, w_ready_nxt;
    logic [NREQ-1:0]    r_resp_valid, w_resp_valid_nxt;
    logic [2*WIDTH-1:0] r_resp_y, w_resp_y_nxt;
    logic               r_resp_err, w_resp_err_nxt;
    logic               r_start, w_start_nxt;
    logic [WIDTH-1:0]   r_mult_a, w_a_nxt;
    logic [WIDTH-1:0]   r_mult_b, w_b_nxt;

    logic [IW-1:0]      w_gnt;
    logic               w_any;
    logic               w_tmo_hit;
    logic [WIDTH-1:0]   w_a_slot [NREQ];
    logic [WIDTH-1:0]   w_b_slot [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_slot
        assign w_a_slot[i] = req_a[i*WIDTH +: WIDTH];
        assign w_b_slot[i] = req_b[i*WIDTH +: WIDTH];
    end

    rr_pick #(
        .NREQ    (NREQ),
        .IW      (IW)
    ) u_rr_pick (
        .req     (req_valid),
        .last    (r_last),
        .gnt_idx (w_gnt),
        .any     (w_any)
    );

    assign w_tmo_hit = (r_tmo == TMO_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_tmo        <= '0;
            r_grant      <= '0;
            r_last       <= LAST_RST;
            r_ready      <= '0;
            r_resp_valid <= '0;
            r_resp_y     <= '0;
            r_resp_err   <= 1'b0;
            r_start      <= 1'b0;
            r_mult_a     <= '0;
            r_mult_b     <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_tmo        <= w_tmo_nxt;
            r_grant      <= w_grant_nxt;
            r_last       <= w_last_nxt;
            r_ready      <= w_ready_nxt;
            r_resp_valid <= w_resp_valid_nxt;
            r_resp_y     <= w_resp_y_nxt;
            r_resp_err   <= w_resp_err_nxt;
            r_start      <= w_start_nxt;
            r_mult_a     <= w_a_nxt;
            r_mult_b     <= w_b_nxt;
        end
    end

    // Next values are the registered outputs for the following cycle, so
    // pulses land exactly in the state they belong to (ready in START, resp in DONE).
    always_comb begin
        w_state_nxt      = r_state;
        w_tmo_nxt        = r_tmo;
        w_grant_nxt      = r_grant;
        w_last_nxt       = r_last;
        w_ready_nxt      = '0;
        w_resp_valid_nxt = '0;
        w_resp_y_nxt     = '0;
        w_resp_err_nxt   = 1'b0;
        w_start_nxt      = 1'b0;
        w_a_nxt          = r_mult_a;
        w_b_nxt          = r_mult_b;
        case (r_state)
            ST_IDLE: begin
                w_tmo_nxt = '0;
                if (w_any) begin
                    w_grant_nxt        = w_gnt;
                    w_a_nxt            = w_a_slot[w_gnt];
                    w_b_nxt            = w_b_slot[w_gnt];
                    w_ready_nxt[w_gnt] = 1'b1;
                    w_start_nxt        = 1'b1;
                    w_state_nxt        = ST_START;
                end
            end
            ST_START: begin
                if (mult_busy) begin
                    w_tmo_nxt   = '0;
                    w_state_nxt = ST_RUN;
                end else if (w_tmo_hit) begin
                    w_tmo_nxt                 = '0;
                    w_resp_valid_nxt[r_grant] = 1'b1;
                    w_resp_err_nxt            = 1'b1;
                    w_state_nxt               = ST_DONE;
                end else begin
                    w_tmo_nxt   = r_tmo + TW'(1);
                    w_start_nxt = 1'b1;
                end
            end
            ST_RUN: begin
                if (!mult_busy) begin
                    w_tmo_nxt                 = '0;
                    w_resp_valid_nxt[r_grant] = 1'b1;
                    w_resp_y_nxt              = mult_y;
                    w_state_nxt               = ST_DONE;
                end else if (w_tmo_hit) begin
                    w_tmo_nxt                 = '0;
                    w_resp_valid_nxt[r_grant] = 1'b1;
                    w_resp_err_nxt            = 1'b1;
                    w_state_nxt               = ST_DONE;
                end else begin
                    w_tmo_nxt = r_tmo + TW'(1);
                end
            end
            ST_DONE: begin
                w_last_nxt  = r_grant;
                w_tmo_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign req_ready  = r_ready;
    assign resp_valid = r_resp_valid;
    assign resp_y     = r_resp_y;
    assign resp_err   = r_resp_err;
    assign mult_start = r_start;
    assign mult_a     = r_mult_a;
    assign mult_b     = r_mult_b;

endmodule

// File: tb/tb_mult_arbiter.sv
// tb/tb_mult_arbiter.sv - self-checking bench for mult_arbiter with a behavioural multiplier
module tb_mult_arbiter;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int TMO = 64;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_a, req_b;
    logic [N-1:0]   req_ready, resp_valid;
    logic [2*W-1:0] resp_y;
    logic           resp_err;
    logic           mult_start;
    logic [W-1:0]   mult_a, mult_b;
    logic           mult_busy;
    logic [2*W-1:0] mult_y;

    mult_arbiter #(.NREQ(N), .WIDTH(W), .TIMEOUT(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_y     (resp_y),
        .resp_err   (resp_err),
        .mult_start (mult_start),
        .mult_a     (mult_a),
        .mult_b     (mult_b),
        .mult_busy  (mult_busy),
        .mult_y     (mult_y)
    );

    always #5 clk = ~clk;

    // Multiplier: mode 0 normal, 1 never raises busy, 2 busy never falls.
    int             m_mode = 0;
    int             m_lat  = 3;
    int             m_cnt;
    logic [2*W-1:0] m_prod;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mult_busy <= 1'b0;
            mult_y    <= '0;
            m_cnt     <= 0;
            m_prod    <= '0;
        end else if (mult_busy) begin
            if (m_mode != 2) begin
                if (m_cnt <= 1) begin
                    mult_busy <= 1'b0;
                    mult_y    <= m_prod;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
        end else if (mult_start && m_mode != 1) begin
            mult_busy <= 1'b1;
            m_cnt     <= m_lat;
            m_prod    <= mult_a * mult_b;
            mult_y    <= 16'($urandom);
        end
    end

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    bit pend = 0;
    bit hold = 0;
    int p_idx, p_a, p_b;
    int m_last;
    int grants[$];
    int ys[$];
    int last_idx, last_y, last_err;
    int resp_cnt = 0;
    int ready_cyc, resp_cyc;
    logic [1:0] bh;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int rr_ref(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (last + k) % N;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input int a, input int b);
        req_valid[i]      = 1'b1;
        req_a[i*W +: W]   = a[W-1:0];
        req_b[i*W +: W]   = b[W-1:0];
    endtask

    task automatic chk_reset_outputs();
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_y", resp_y, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_mult_start", mult_start, 0);
        chk("rst_mult_a", mult_a, 0);
        chk("rst_mult_b", mult_b, 0);
    endtask

    // Reset asserted between clock edges so only an asynchronous reset clears outputs in time.
    task automatic do_reset();
        #2 rst = 1'b0;
        #1 chk_reset_outputs();
        req_valid = '0;
        pend      = 0;
        hold      = 0;
        m_last    = N - 1;
        m_mode    = 0;
        bh        = 2'b00;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic cycle();
        logic [N-1:0]   sv;
        logic [N*W-1:0] sa, sb;
        int g, ey;
        sv = req_valid;
        sa = req_a;
        sb = req_b;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (req_ready != 0) begin
            g = rr_ref(sv, m_last);
            chk("grant_onehot", req_ready, (g < 0) ? 64'd0 : (64'd1 << g));
            chk("grant_while_busy", pend, 0);
            if (g >= 0) begin
                pend      = 1;
                p_idx     = g;
                p_a       = int'(sa[g*W +: W]);
                p_b       = int'(sb[g*W +: W]);
                m_last    = g;
                ready_cyc = cyc;
                grants.push_back(g);
                chk("latched_a", mult_a, p_a);
                chk("latched_b", mult_b, p_b);
                req_a[g*W +: W] = 8'($urandom);
                req_b[g*W +: W] = 8'($urandom);
                if (!hold) req_valid[g] = 1'b0;
            end
        end else if (pend) begin
            chk("operand_hold", {mult_a, mult_b}, {p_a[7:0], p_b[7:0]});
        end
        if (resp_valid != 0) begin
            chk("resp_expected", pend, 1);
            ey = (m_mode == 0) ? p_a * p_b : 0;
            chk("resp_onehot", resp_valid, 64'd1 << p_idx);
            chk("resp_y", resp_y, ey);
            chk("resp_err", resp_err, (m_mode != 0) ? 1 : 0);
            if (m_mode == 0) chk("resp_after_busy_fall", bh, 2'b10);
            for (int i = 0; i < N; i++) if (resp_valid[i]) last_idx = i;
            last_y   = int'(resp_y);
            last_err = int'(resp_err);
            ys.push_back(last_y);
            resp_cnt++;
            resp_cyc = cyc;
            pend     = 0;
        end
        bh = {bh[0], mult_busy};
    endtask

    task automatic wait_resp(input int target, input int bound);
        for (int k = 0; k < bound && resp_cnt < target; k++) cycle();
        chk("resp_count", resp_cnt, target);
    endtask

    initial begin
        int t0, base, rg;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        do_reset();

        // Single request, latency from request to ready and from ready to response
        set_req(0, 3, 4);
        t0 = cyc;
        wait_resp(resp_cnt + 1, 200);
        chk("t1_ready_latency", ready_cyc, t0 + 1);
        chk("t1_resp_latency", resp_cyc - ready_cyc, m_lat + 2);
        chk("t1_idx", last_idx, 0);
        chk("t1_y", last_y, 12);
        chk("t1_err", last_err, 0);

        // Two simultaneous requesters from reset
        do_reset();
        grants.delete();
        ys.delete();
        set_req(0, 5, 12);
        set_req(2, 8, 7);
        wait_resp(resp_cnt + 2, 300);
        chk("t2_count", grants.size(), 2);
        chk("t2_first_grant", grants[0], 0);
        chk("t2_first_y", ys[0], 60);
        chk("t2_second_grant", grants[1], 2);
        chk("t2_second_y", ys[1], 56);

        // All requesters held valid: strict rotation
        do_reset();
        grants.delete();
        hold = 1;
        for (int i = 0; i < N; i++) set_req(i, $urandom, $urandom);
        base = resp_cnt;
        for (int k = 0; k < 2000 && grants.size() < 8; k++) cycle();
        hold = 0;
        req_valid = '0;
        wait_resp(base + 8, 300);
        for (int i = 0; i < 8; i++) chk("t3_rotation", grants[i], i % N);

        // Busy never rises: timeout in START, then a normal operation
        do_reset();
        m_mode = 1;
        set_req(1, 9, 9);
        wait_resp(resp_cnt + 1, 300);
        chk("t4_idx", last_idx, 1);
        chk("t4_err", last_err, 1);
        chk("t4_y", last_y, 0);
        chk("t4_start_cycles", resp_cyc - ready_cyc, TMO);
        m_mode = 0;
        set_req(2, 6, 7);
        wait_resp(resp_cnt + 1, 200);
        chk("t4_recover_y", last_y, 42);

        // Busy never falls: timeout in RUN
        m_mode = 2;
        set_req(3, 11, 13);
        wait_resp(resp_cnt + 1, 300);
        chk("t4b_idx", last_idx, 3);
        chk("t4b_err", last_err, 1);
        chk("t4b_run_cycles", resp_cyc - ready_cyc, TMO + 2);

        // Reset while the multiplier is busy
        do_reset();
        m_lat = 12;
        set_req(2, 7, 7);
        for (int k = 0; k < 50 && !(pend && mult_busy); k++) cycle();
        chk("t5_reached_run", pend && mult_busy, 1);
        repeat (3) cycle();
        base = resp_cnt;
        do_reset();
        repeat (20) cycle();
        chk("t5_no_aborted_resp", resp_cnt, base);
        m_lat = 3;
        grants.delete();
        ys.delete();
        set_req(0, 1, 1);
        set_req(1, 5, 5);
        wait_resp(resp_cnt + 2, 300);
        chk("t5_first_grant", grants[0], 0);
        chk("t5_first_y", ys[0], 1);

        // Operand corners
        set_req(0, 255, 255);
        wait_resp(resp_cnt + 1, 200);
        chk("t6_max_y", last_y, 65025);
        chk("t6_max_err", last_err, 0);
        set_req(3, 0, 200);
        wait_resp(resp_cnt + 1, 200);
        chk("t6_zero_y", last_y, 0);
        chk("t6_zero_err", last_err, 0);

        // Random traffic against the round-robin/product model
        grants.delete();
        for (int k = 0; k < 1500; k++) begin
            m_lat = $urandom_range(1, 6);
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(0, 3) == 0)
                    set_req(i, $urandom, $urandom);
                else if (req_valid[i] && $urandom_range(0, 15) == 0)
                    req_valid[i] = 1'b0;
            end
            cycle();
        end
        rg = grants.size();
        req_valid = '0;
        for (int k = 0; k < 200 && pend; k++) cycle();
        chk("rand_drain", pend, 0);
        chk("rand_activity", (rg > 20) ? 1 : 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
